mem_periph_responder: RTL and testbench

- Memory-mapped peripheral responder on the CPU data-memory port.
- The MEM stage is the initiator; this block answers its loads and stores in the 0x4000_0000 window.
- Contains an interval timer with an interrupt, LED/7-segment output registers, a synchronized switch input and a free-running cycle counter.
- Its irq output drives the CPU's interrupt input; its bad_addr output feeds the exception path.

---
 rtl/periph_pkg.sv | 25 ++
 rtl/periph_timer.sv | 33 +++
 rtl/uart_tx_fsm.sv | 60 ++++++
 rtl/mem_periph_responder.sv | 85 ++++++++
 tb/tb_mem_periph_responder.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/periph_pkg.sv
// periph_pkg: register offsets, TCON bit indices and decode constants for mem_periph_responder
package periph_pkg;
  localparam logic [31:0] BASE_ADDR_DEF = 32'h4000_0000;
  localparam logic [5:0] OFF_TH   = 6'h00;
  localparam logic [5:0] OFF_TL   = 6'h04;
  localparam logic [5:0] OFF_TCON = 6'h08;
  localparam logic [5:0] OFF_LED  = 6'h0C;
  localparam logic [5:0] OFF_SW   = 6'h10;
  localparam logic [5:0] OFF_DIGI = 6'h14;
  localparam logic [5:0] OFF_TICK = 6'h18;
  localparam logic [5:0] OFF_UTX  = 6'h1C;
  localparam logic [5:0] OFF_UST  = 6'h20;
  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;
`ifdef PERIPH_UART_TX_EN
  // UART_STAT sits at 0x20, so the window grows to 64 bytes
  localparam int DEC_LSB = 6;
  localparam logic [5:0] OFF_MAX = OFF_UST;
`else
  localparam int DEC_LSB = 5;
  localparam logic [5:0] OFF_MAX = OFF_TICK;
`endif
  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_e;
endpackage

// File: rtl/periph_timer.sv
// periph_timer: TH/TL/TCON interval timer with reload, sticky status and registered irq
module periph_timer
  import periph_pkg::*;
(
  input  logic        clk,
  input  logic        reset_b,
  input  logic [31:0] wdata,
  input  logic        we_th,
  input  logic        we_tl,
  input  logic        we_tcon,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        irq
);
  logic ovf;
  assign ovf = tcon[TCON_EN] && tl == 32'hFFFF_FFFF;
  // CPU writes beat the count; an overflow status set beats a CPU clear
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
      irq  <= 1'b0;
    end else begin
      if (we_th) th <= wdata;
      tl <= we_tl ? wdata : ovf ? th : tcon[TCON_EN] ? tl + 32'd1 : tl;
      tcon[1:0] <= we_tcon ? wdata[1:0] : tcon[1:0];
      tcon[TCON_ST] <= (we_tcon ? wdata[2] : tcon[TCON_ST]) | (ovf & tcon[TCON_IE]);
      irq <= tcon[TCON_ST] & tcon[TCON_IE];
    end
  end
endmodule

// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: 8N1 LSB-first transmitter, each bit BAUD_DIV cycles, idle line high
module uart_tx_fsm
  import periph_pkg::*;
#(
  parameter int BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);
  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
  uart_state_e st;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] sh;
  assign busy = st != U_IDLE;
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      st  <= U_IDLE;
      tx  <= 1'b1;
      cnt <= '0;
      idx <= '0;
      sh  <= '0;
    end else if (st == U_IDLE) begin
      if (start) begin
        st  <= U_START;
        tx  <= 1'b0;
        sh  <= data;
        cnt <= '0;
      end
    end else if (cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
      case (st)
        U_START: begin
          st  <= U_DATA;
          tx  <= sh[0];
          sh  <= sh >> 1;
          idx <= '0;
        end
        U_DATA: begin
          if (idx == 3'd7) begin
            st <= U_STOP;
            tx <= 1'b1;
          end else begin
            tx  <= sh[0];
            sh  <= sh >> 1;
            idx <= idx + 1'b1;
          end
        end
        default: st <= U_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/mem_periph_responder.sv
// mem_periph_responder: MEM-stage peripheral window (timer, LED, 7-seg, switches, SYSTICK); PERIPH_UART_TX_EN adds a UART transmitter
module mem_periph_responder
  import periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter int LED_W = 8,
  parameter int SW_W = 8
`ifdef PERIPH_UART_TX_EN
  , parameter int BAUD_DIV = 5208
`endif
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic [31:0]      rdata,
  output logic             bad_addr,
  output logic             irq,
  output logic [LED_W-1:0] leds,
  output logic [11:0]      digi,
  input  logic [SW_W-1:0]  switches
`ifdef PERIPH_UART_TX_EN
  , output logic           uart_tx
`endif
);
  logic hit, rd, we;
  logic [5:0] off;
  logic [31:0] th, tl, systick, rsel;
  logic [2:0] tcon;
  logic [SW_W-1:0] sw_s1, sw_s2;
  logic unused_addr;
  assign unused_addr = ^addr[1:0];
  assign hit = addr[31:DEC_LSB] == BASE_ADDR[31:DEC_LSB];
  assign rd = mem_read && hit;
  assign we = mem_write && hit;
`ifdef PERIPH_UART_TX_EN
  logic tx_busy;
  assign off = {addr[5:2], 2'b00};
  uart_tx_fsm #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk(clk), .reset_b(reset_b), .start(we && off == OFF_UTX),
    .data(wdata[7:0]), .tx(uart_tx), .busy(tx_busy)
  );
`else
  assign off = {1'b0, addr[4:2], 2'b00};
`endif
  periph_timer u_timer (
    .clk(clk), .reset_b(reset_b), .wdata(wdata),
    .we_th(we && off == OFF_TH), .we_tl(we && off == OFF_TL),
    .we_tcon(we && off == OFF_TCON),
    .th(th), .tl(tl), .tcon(tcon), .irq(irq)
  );
  always_comb begin
    rsel = off == OFF_TH   ? th :
           off == OFF_TL   ? tl :
           off == OFF_TCON ? {29'd0, tcon} :
           off == OFF_LED  ? 32'(leds) :
           off == OFF_SW   ? 32'(sw_s2) :
           off == OFF_DIGI ? {20'd0, digi} :
           off == OFF_TICK ? systick :
`ifdef PERIPH_UART_TX_EN
           off == OFF_UST  ? {31'd0, tx_busy} :
`endif
           32'd0;
    rdata = rd ? rsel : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      leds     <= '0;
      digi     <= '0;
      systick  <= '0;
      sw_s1    <= '0;
      sw_s2    <= '0;
      bad_addr <= 1'b0;
    end else begin
      if (we && off == OFF_LED) leds <= wdata[LED_W-1:0];
      if (we && off == OFF_DIGI) digi <= wdata[11:0];
      systick  <= systick + 32'd1;
      sw_s1    <= switches;
      sw_s2    <= sw_s1;
      bad_addr <= (mem_read || mem_write) && hit && off > OFF_MAX;
    end
  end
endmodule

// File: tb/tb_mem_periph_responder.sv
// tb_mem_periph_responder: directed vectors for mem_periph_responder (define PERIPH_UART_TX_EN to add the UART checks)
`timescale 1ns/100ps
module tb_mem_periph_responder;
  localparam logic [31:0] BASE = 32'h4000_0000;
`ifdef PERIPH_UART_TX_EN
  localparam logic [31:0] BAD_A = 32'h4000_0024;
`else
  localparam logic [31:0] BAD_A = 32'h4000_001C;
`endif
  logic clk = 0, reset_b = 0, mem_read = 0, mem_write = 0;
  logic [31:0] addr = 0, wdata = 0, rdata;
  logic bad_addr, irq;
  logic [7:0] leds, switches = 0;
  logic [11:0] digi;
  logic [31:0] cyc = 0;
  int nvec = 0, nbad = 0;
`ifdef PERIPH_UART_TX_EN
  logic uart_tx;
  logic [9:0] frame;
`endif
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= reset_b ? cyc + 1 : 0;
`ifdef PERIPH_UART_TX_EN
  mem_periph_responder #(.BAUD_DIV(4)) dut (
    .clk(clk), .reset_b(reset_b), .addr(addr), .wdata(wdata),
    .mem_read(mem_read), .mem_write(mem_write), .rdata(rdata),
    .bad_addr(bad_addr), .irq(irq), .leds(leds), .digi(digi),
    .switches(switches), .uart_tx(uart_tx)
  );
`else
  mem_periph_responder dut (
    .clk(clk), .reset_b(reset_b), .addr(addr), .wdata(wdata),
    .mem_read(mem_read), .mem_write(mem_write), .rdata(rdata),
    .bad_addr(bad_addr), .irq(irq), .leds(leds), .digi(digi),
    .switches(switches)
  );
`endif
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [5:0] off, input logic [31:0] d);
    addr = BASE + 32'(off);
    wdata = d;
    mem_write = 1;
    tick;
    mem_write = 0;
  endtask
  task automatic chk_rd(input string tag, input logic [5:0] off, input logic [31:0] exp);
    addr = BASE + 32'(off);
    mem_read = 1;
    #1;
    chk(tag, rdata, exp);
    mem_read = 0;
  endtask
  initial begin
    tick;
    tick;
    reset_b = 1;
    chk_rd("rst_th", 6'h00, 0);
    chk_rd("rst_tl", 6'h04, 0);
    chk_rd("rst_tcon", 6'h08, 0);
    chk_rd("rst_led", 6'h0C, 0);
    chk_rd("rst_digi", 6'h14, 0);
    chk_rd("rst_tick", 6'h18, 0);
    chk("rst_irq", {31'd0, irq}, 0);
    chk("rst_leds", {24'd0, leds}, 0);
    chk("rst_bad", {31'd0, bad_addr}, 0);
    addr = BASE + 32'h0C;
    #1;
    chk("noread_rdata", rdata, 0);
    wr(6'h00, 32'hFFFF_FFFC);
    wr(6'h04, 32'hFFFF_FFFE);
    wr(6'h08, 32'h3);
    chk_rd("tl_e0", 6'h04, 32'hFFFF_FFFE);
    tick;
    chk_rd("tl_e1", 6'h04, 32'hFFFF_FFFF);
    chk_rd("tcon_e1", 6'h08, 32'h3);
    tick;
    chk_rd("tl_reload", 6'h04, 32'hFFFF_FFFC);
    chk_rd("tcon_set", 6'h08, 32'h7);
    chk("irq_e2", {31'd0, irq}, 0);
    tick;
    chk("irq_rise", {31'd0, irq}, 1);
    chk_rd("tl_e3", 6'h04, 32'hFFFF_FFFD);
    wr(6'h08, 32'h3);
    chk_rd("tcon_clr", 6'h08, 32'h3);
    chk("irq_hold", {31'd0, irq}, 1);
    tick;
    chk("irq_drop", {31'd0, irq}, 0);
    chk_rd("tl_e5", 6'h04, 32'hFFFF_FFFF);
    wr(6'h08, 32'h3);
    chk_rd("tcon_collide", 6'h08, 32'h7);
    chk_rd("tl_e6", 6'h04, 32'hFFFF_FFFC);
    tick;
    chk("irq_again", {31'd0, irq}, 1);
    wr(6'h04, 32'h100);
    chk_rd("tl_wr_wins", 6'h04, 32'h100);
    tick;
    chk_rd("tl_count", 6'h04, 32'h101);
    reset_b = 0;
    tick;
    reset_b = 1;
    chk_rd("mid_rst_tl", 6'h04, 0);
    chk_rd("mid_rst_th", 6'h00, 0);
    chk_rd("mid_rst_tcon", 6'h08, 0);
    chk("mid_rst_irq", {31'd0, irq}, 0);
    wr(6'h08, 32'hFFFF_FFF4);
    chk_rd("tcon_upper", 6'h08, 32'h4);
    wr(6'h0C, 32'h1234_56A5);
    chk("leds", {24'd0, leds}, 32'hA5);
    chk_rd("led_rd", 6'h0C, 32'hA5);
    wr(6'h14, 32'hFFFF_FABC);
    chk("digi", {20'd0, digi}, 32'hABC);
    chk_rd("digi_rd", 6'h14, 32'hABC);
    addr = BASE + 32'h0C;
    wdata = 32'h3C;
    mem_read = 1;
    mem_write = 1;
    #1;
    chk("rw_old", rdata, 32'hA5);
    tick;
    mem_read = 0;
    mem_write = 0;
    chk("rw_new", {24'd0, leds}, 32'h3C);
    switches = 8'hA5;
    chk_rd("sw_e0", 6'h10, 0);
    tick;
    chk_rd("sw_e1", 6'h10, 0);
    tick;
    chk_rd("sw_e2", 6'h10, 32'hA5);
    wr(6'h10, 32'h0);
    chk_rd("sw_ro", 6'h10, 32'hA5);
    wr(6'h18, 32'h0);
    chk_rd("tick_ro", 6'h18, cyc);
    tick;
    chk_rd("tick_inc", 6'h18, cyc);
    addr = BAD_A;
    mem_read = 1;
    #1;
    chk("bad_rdata", rdata, 0);
    tick;
    mem_read = 0;
    chk("bad_set", {31'd0, bad_addr}, 1);
    tick;
    chk("bad_clr", {31'd0, bad_addr}, 0);
    addr = 32'h4000_0040;
    mem_read = 1;
    #1;
    chk("out40_rdata", rdata, 0);
    tick;
    mem_read = 0;
    chk("out40_bad", {31'd0, bad_addr}, 0);
    addr = 32'h1000_0000;
    mem_read = 1;
    #1;
    chk("out_rdata", rdata, 0);
    tick;
    mem_read = 0;
    chk("out_bad", {31'd0, bad_addr}, 0);
`ifdef PERIPH_UART_TX_EN
    frame = {1'b1, 8'h55, 1'b0};
    chk("uart_idle", {31'd0, uart_tx}, 1);
    wr(6'h1C, 32'h55);
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("uart_bit%0d", i), {31'd0, uart_tx}, {31'd0, frame[i/4]});
      chk_rd("uart_busy", 6'h20, 1);
      if (i == 10) wr(6'h1C, 32'hFF);
      else tick;
    end
    chk_rd("uart_done", 6'h20, 0);
    chk("uart_line", {31'd0, uart_tx}, 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
